// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci generator / seed-recovery pair.
package fib_pkg;

    localparam int unsigned FIB_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT1  = 2'd1,
        TRACK = 2'd2,
        ERROR = 2'd3
    } fib_state_t;

endpackage

// File: rtl/fib_step_check.sv
// Combinational Fibonacci step: sum = p0 + p1 (mod 2^W), hit when x equals that sum.
import fib_pkg::*;

module fib_step_check #(
    parameter int unsigned W = FIB_W
) (
    input  logic [W-1:0] p0,
    input  logic [W-1:0] p1,
    input  logic [W-1:0] x,
    output logic [W-1:0] sum,
    output logic         hit
);

    assign sum = p0 + p1;
    assign hit = (x == sum);

endmodule

// File: rtl/fib_seed_recover.sv
// Recovers Fibonacci seeds from the first two stream terms, then checks the recurrence.
// Optional FIB_RESYNC_EN: on mismatch, pulse err and resynchronise instead of locking in ERROR.
import fib_pkg::*;

module fib_seed_recover #(
    parameter int unsigned W  = FIB_W,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          seed_valid,
    output logic [W-1:0]  f0_out,
    output logic [W-1:0]  f1_out,
    output logic [CW-1:0] match_cnt,
    output logic          err
);

    fib_state_t    state_q, state_d;
    logic [W-1:0]  p0_q, p0_d;
    logic [W-1:0]  p1_q, p1_d;
    logic [W-1:0]  f0_q, f0_d;
    logic [W-1:0]  f1_q, f1_d;
    logic          seed_valid_q, seed_valid_d;
    logic [CW-1:0] match_cnt_q, match_cnt_d;
    logic          err_q, err_d;

    logic [W-1:0]  sum;
    logic          hit;
    logic [W-1:0]  diff;
    logic          accept;

    fib_step_check #(.W(W)) u_step (
        .p0  (p0_q),
        .p1  (p1_q),
        .x   (in_data),
        .sum (sum),
        .hit (hit)
    );

    assign in_ready = (state_q != ERROR);
    assign accept   = in_valid & in_ready;
    assign diff     = in_data - p0_q;

    always_comb begin
        state_d      = state_q;
        p0_d         = p0_q;
        p1_d         = p1_q;
        f0_d         = f0_q;
        f1_d         = f1_q;
        seed_valid_d = seed_valid_q;
        match_cnt_d  = match_cnt_q;
`ifdef FIB_RESYNC_EN
        err_d        = 1'b0;
`else
        err_d        = err_q;
`endif
        if (clr) begin
            state_d      = IDLE;
            p0_d         = '0;
            p1_d         = '0;
            f0_d         = '0;
            f1_d         = '0;
            seed_valid_d = 1'b0;
            match_cnt_d  = '0;
            err_d        = 1'b0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    p0_d    = in_data;
                    state_d = GOT1;
                end
                GOT1: begin
                    // x = f0 + 2*f1 and p0 = f0 + f1, so f1 = x - p0 and f0 = p0 - f1
                    p1_d         = in_data;
                    f1_d         = diff;
                    f0_d         = p0_q - diff;
                    seed_valid_d = 1'b1;
                    state_d      = TRACK;
                end
                TRACK: begin
                    if (hit) begin
                        p0_d = p1_q;
                        p1_d = in_data;
                        if (match_cnt_q != '1)
                            match_cnt_d = match_cnt_q + CW'(1);
                    end else begin
                        err_d = 1'b1;
`ifdef FIB_RESYNC_EN
                        p0_d         = in_data;
                        seed_valid_d = 1'b0;
                        state_d      = GOT1;
`else
                        state_d      = ERROR;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            p0_q         <= '0;
            p1_q         <= '0;
            f0_q         <= '0;
            f1_q         <= '0;
            seed_valid_q <= 1'b0;
            match_cnt_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            p0_q         <= p0_d;
            p1_q         <= p1_d;
            f0_q         <= f0_d;
            f1_q         <= f1_d;
            seed_valid_q <= seed_valid_d;
            match_cnt_q  <= match_cnt_d;
            err_q        <= err_d;
        end
    end

    assign seed_valid = seed_valid_q;
    assign f0_out     = f0_q;
    assign f1_out     = f1_q;
    assign match_cnt  = match_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fib_seed_recover.sv
// Directed self-checking bench for fib_seed_recover (default build, or FIB_RESYNC_EN when defined).
module tb_fib_seed_recover;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_data;
    logic       seed_valid;
    logic [5:0] f0_out;
    logic [5:0] f1_out;
    logic [7:0] match_cnt;
    logic       err;

    int checks = 0;
    int errors = 0;

    fib_seed_recover #(.W(6), .CW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .seed_valid (seed_valid),
        .f0_out     (f0_out),
        .f1_out     (f1_out),
        .match_cnt  (match_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [5:0] x);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic chk_seeds(input string name, input logic [5:0] ef0, input logic [5:0] ef1,
                             input logic [7:0] ecnt);
        checks++;
        if (seed_valid !== 1'b1 || f0_out !== ef0 || f1_out !== ef1 || match_cnt !== ecnt || err !== 1'b0) begin
            errors++;
            $display("FAIL %s: got sv=%b f0=%0d f1=%0d cnt=%0d err=%b, want sv=1 f0=%0d f1=%0d cnt=%0d err=0",
                     name, seed_valid, f0_out, f1_out, match_cnt, err, ef0, ef1, ecnt);
        end
    endtask

    task automatic chk_zero(input string name);
        checks++;
        if (seed_valid !== 1'b0 || f0_out !== 6'd0 || f1_out !== 6'd0 || match_cnt !== 8'd0 ||
            err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: got sv=%b f0=%0d f1=%0d cnt=%0d err=%b rdy=%b, want all 0 and rdy=1",
                     name, seed_valid, f0_out, f1_out, match_cnt, err, in_ready);
        end
    endtask

    task automatic test_reset();
        chk_zero("reset_state");
        rst = 1'b0;
        idle(1);
        chk_zero("after_reset_release");
    endtask

    task automatic test_basic();
        do_clr();
        send(6'd2);
        checks++;
        if (seed_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_sv_after_1: got %b want 0", seed_valid);
        end
        send(6'd3);
        chk_seeds("basic_seeds", 6'd1, 6'd1, 8'd0);
        send(6'd5);
        send(6'd8);
        send(6'd13);
        chk_seeds("basic_final", 6'd1, 6'd1, 8'd3);
    endtask

    task automatic test_wrap();
        logic [5:0] s1 [0:4];
        logic [5:0] s2 [0:8];
        s1 = '{6'd6, 6'd16, 6'd22, 6'd38, 6'd60};
        s2 = '{6'd2, 6'd3, 6'd5, 6'd8, 6'd13, 6'd21, 6'd34, 6'd55, 6'd25};
        do_clr();
        for (int i = 0; i < 5; i++) send(s1[i]);
        chk_seeds("wrap_seeds_60_10", 6'd60, 6'd10, 8'd3);
        do_clr();
        for (int i = 0; i < 9; i++) send(s2[i]);
        chk_seeds("wrap_long_stream", 6'd1, 6'd1, 8'd7);
    endtask

`ifndef FIB_RESYNC_EN
    task automatic test_mismatch();
        do_clr();
        send(6'd2);
        send(6'd3);
        send(6'd5);
        send(6'd9);
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b0 || match_cnt !== 8'd1 || seed_valid !== 1'b1 ||
            f0_out !== 6'd1 || f1_out !== 6'd1) begin
            errors++;
            $display("FAIL mismatch_error: got err=%b rdy=%b cnt=%0d sv=%b f0=%0d f1=%0d, want 1 0 1 1 1 1",
                     err, in_ready, match_cnt, seed_valid, f0_out, f1_out);
        end
        send(6'd14);
        idle(2);
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b0 || match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL mismatch_sticky: got err=%b rdy=%b cnt=%0d, want 1 0 1", err, in_ready, match_cnt);
        end
        do_clr();
        chk_zero("mismatch_clr");
    endtask
`else
    task automatic test_resync();
        do_clr();
        send(6'd2);
        send(6'd3);
        send(6'd5);
        send(6'd9);
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b1 || seed_valid !== 1'b0 || match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL resync_pulse: got err=%b rdy=%b sv=%b cnt=%0d, want 1 1 0 1",
                     err, in_ready, seed_valid, match_cnt);
        end
        idle(1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL resync_pulse_width: got err=%b want 0", err);
        end
        send(6'd10);
        chk_seeds("resync_seeds", 6'd8, 6'd1, 8'd1);
        send(6'd19);
        chk_seeds("resync_final", 6'd8, 6'd1, 8'd2);
    endtask
`endif

    task automatic test_bubbles();
        logic [5:0] s [0:4];
        s = '{6'd2, 6'd3, 6'd5, 6'd8, 6'd13};
        do_clr();
        for (int i = 0; i < 5; i++) begin
            send(s[i]);
            idle(i % 3 + 1);
        end
        chk_seeds("bubbles_final", 6'd1, 6'd1, 8'd3);
    endtask

    task automatic test_clr_priority();
        do_clr();
        send(6'd2);
        send(6'd3);
        send(6'd5);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 6'd7;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        chk_zero("clr_with_valid");
        send(6'd2);
        send(6'd3);
        chk_seeds("clr_term_dropped", 6'd1, 6'd1, 8'd0);
    endtask

    task automatic test_async_reset();
        do_clr();
        send(6'd2);
        send(6'd3);
        send(6'd5);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_reset_immediate");
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(6'd2);
        send(6'd3);
        send(6'd5);
        send(6'd8);
        send(6'd13);
        chk_seeds("async_reset_restart", 6'd1, 6'd1, 8'd3);
    endtask

    task automatic test_saturate();
        do_clr();
        for (int i = 0; i < 300; i++) send(6'd0);
        chk_seeds("match_cnt_saturate", 6'd0, 6'd0, 8'd255);
    endtask

    initial begin
        rst      = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_wrap();
`ifndef FIB_RESYNC_EN
        test_mismatch();
`else
        test_resync();
`endif
        test_bubbles();
        test_clr_priority();
        test_async_reset();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
